// File: rtl/img_sector_bridge.sv
// img_sector_bridge
// Moves one 512-byte sector between a mounted disk image (HPS side) and a
// 256x16 sector buffer shared with the core. A request is checked against
// the current mount state. Then sd_rd/sd_wr is raised until the HPS acks,
// and completion is reported on the falling edge of sd_ack.
//
// Ports
//   clk_sys, reset                 clock, synchronous active-high reset
//   img_mounted/img_size/_readonly mount pulse with image size and write-protect
//   req_valid/req_ready            sector request handshake
//   req_write, req_lba             direction (1 = buffer to image), sector number
//   done, err                      one-cycle completion pulse, err valid with done
//   core_addr/wdata/we, core_rdata core buffer port, registered read
//   sd_lba, sd_rd, sd_wr, sd_ack   HPS request strobes and transfer-in-progress
//   sd_buff_addr/dout/wr, _din     HPS buffer port, writes gated by sd_ack
//
// state | meaning
// IDLE  | ready for a request
// CHECK | validate lba/direction against mount state
// REQ   | strobe held, waiting for sd_ack, timeout running
// XFER  | HPS transferring, waiting for sd_ack to fall
// DONE  | done pulse, back to IDLE
module img_sector_bridge #(
  parameter int unsigned ACK_TIMEOUT = 2**24
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  input  logic        img_readonly,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_lba,
  output logic        done,
  output logic        err,
  input  logic [7:0]  core_addr,
  input  logic [15:0] core_wdata,
  input  logic        core_we,
  output logic [15:0] core_rdata,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [15:0] sd_buff_din
);

  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LOAD = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_XFER, S_DONE} state_t;

  state_t        state_q;
  logic          mounted_q, ro_q;
  logic [31:0]   nsect_q;
  logic [31:0]   lba_q;
  logic          write_q;
  logic [CW-1:0] tmo_q;
  logic          ack_q;
  logic          xfer_err_q;
  logic          req_ready_q, done_q, err_q, sd_rd_q, sd_wr_q;
  logic [31:0]   sd_lba_q;
  logic [15:0]   ram_q [0:255];
  logic [15:0]   core_rdata_q, sd_buff_din_q;

  // Sector buffer: read-before-write on both ports; RAM is not reset.
  always_ff @(posedge clk_sys) begin
    if (sd_buff_wr && sd_ack) ram_q[sd_buff_addr] <= sd_buff_dout;
    if (core_we) ram_q[core_addr] <= core_wdata;
    core_rdata_q  <= ram_q[core_addr];
    sd_buff_din_q <= ram_q[sd_buff_addr];
  end

  // Mount state updates in any FSM state, so a request accepted in the same
  // cycle as a mount pulse is checked against the new image.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mounted_q <= 1'b0;
      ro_q      <= 1'b0;
      nsect_q   <= '0;
    end else if (img_mounted) begin
      mounted_q <= (img_size != 64'd0);
      ro_q      <= img_readonly;
      nsect_q   <= img_size[40:9];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lba_q       <= '0;
      write_q     <= 1'b0;
      tmo_q       <= '0;
      ack_q       <= 1'b0;
      xfer_err_q  <= 1'b0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      sd_lba_q    <= '0;
    end else begin
      ack_q  <= sd_ack;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            lba_q       <= req_lba;
            write_q     <= req_write;
            req_ready_q <= 1'b0;
            state_q     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!mounted_q || (lba_q >= nsect_q) || (write_q && ro_q)) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            sd_lba_q   <= lba_q;
            sd_rd_q    <= !write_q;
            sd_wr_q    <= write_q;
            tmo_q      <= TMO_LOAD;
            xfer_err_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          // A remount while waiting invalidates the request outright.
          if (img_mounted || (!sd_ack && (tmo_q == '0))) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (sd_ack) begin
            sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;
            state_q <= S_XFER;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        S_XFER: begin
          // The HPS transfer cannot be cancelled; a remount only taints the result.
          if (img_mounted) xfer_err_q <= 1'b1;
          if (ack_q && !sd_ack) begin
            done_q  <= 1'b1;
            err_q   <= xfer_err_q | img_mounted;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          err_q       <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign done        = done_q;
  assign err         = err_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign sd_lba      = sd_lba_q;
  assign core_rdata  = core_rdata_q;
  assign sd_buff_din = sd_buff_din_q;

endmodule

// File: tb/tb_img_sector_bridge.sv
// Testbench for img_sector_bridge: directed sector scenarios plus randomized
// transactions checked against a transaction-level model of the bridge.
module tb_img_sector_bridge;
  localparam int TMO = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        img_mounted;
  logic [63:0] img_size;
  logic        img_readonly;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_lba;
  logic        done, err;
  logic [7:0]  core_addr;
  logic [15:0] core_wdata;
  logic        core_we;
  logic [15:0] core_rdata;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din;

  always #5 clk_sys = ~clk_sys;

  img_sector_bridge #(.ACK_TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .img_mounted(img_mounted), .img_size(img_size), .img_readonly(img_readonly),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_lba(req_lba),
    .done(done), .err(err),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we), .core_rdata(core_rdata),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] mem [256];
  bit          m_mounted;
  bit          m_ro;
  logic [31:0] m_nsect;
  logic [31:0] exp_lba;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_mount(input logic [63:0] size, input bit ro);
    m_mounted = (size != 64'd0);
    m_ro      = ro;
    m_nsect   = 32'(size / 64'd512);
  endfunction

  task automatic do_mount(input logic [63:0] size, input bit ro);
    @(posedge clk_sys); #1;
    img_mounted = 1'b1; img_size = size; img_readonly = ro;
    @(posedge clk_sys); #1;
    img_mounted = 1'b0;
    model_mount(size, ro);
  endtask

  task automatic core_fill(input bit pat);
    for (int a = 0; a < 256; a++) begin
      @(posedge clk_sys); #1;
      core_we    = 1'b1;
      core_addr  = 8'(a);
      core_wdata = pat ? (16'hA5A5 ^ 16'(a)) : 16'($urandom);
      mem[a]     = core_wdata;
    end
    @(posedge clk_sys); #1;
    core_we = 1'b0;
  endtask

  task automatic core_check();
    for (int a = 0; a <= 256; a++) begin
      @(posedge clk_sys); #1;
      if (a < 256) core_addr = 8'(a);
      @(negedge clk_sys);
      if (a > 0) chk("core_rd", core_rdata, mem[a-1]);
    end
  endtask

  // One request with an HPS that acks ack_dly cycles after the strobe and
  // holds ack for ack_len cycles. mnt_k: -1 none, 0 with the request,
  // k>=2 mount pulse during cycle k after acceptance.
  task automatic run_req(input bit wr, input logic [31:0] lba, input bit ack_en,
                         input int ack_dly, input int ack_len, input int mnt_k,
                         input logic [63:0] n_size, input bit n_ro,
                         input bit seq_data, input logic [7:0] base);
    bit chk_err, e_err, got_err, fired, cur_v, prev_v, ackon;
    int e_ks, e_scyc, e_done, ka, ks, scyc, done_k, wrong, busy, buf_bad, limit, j, idx;
    logic [7:0]  cur_a, prev_a;
    logic [15:0] d;
    @(posedge clk_sys); #1;
    req_valid = 1'b1; req_write = wr; req_lba = lba;
    if (mnt_k == 0) begin
      img_mounted = 1'b1; img_size = n_size; img_readonly = n_ro;
      model_mount(n_size, n_ro);
    end
    @(posedge clk_sys); #1;
    req_valid = 1'b0; img_mounted = 1'b0;

    chk_err = !m_mounted || (lba >= m_nsect) || (wr && m_ro);
    ka = 2 + ack_dly;
    if (chk_err) begin
      e_ks = -1; e_scyc = 0; e_done = 2; e_err = 1'b1;
    end else begin
      exp_lba = lba;
      e_ks = 2;
      if (mnt_k >= 2 && (!ack_en || mnt_k < ka)) begin
        e_scyc = mnt_k - 1; e_done = mnt_k + 1; e_err = 1'b1;
      end else if (!ack_en) begin
        e_scyc = TMO; e_done = 2 + TMO; e_err = 1'b1;
      end else begin
        e_scyc = ack_dly + 1; e_done = ka + ack_len + 1;
        e_err  = (mnt_k > ka) && (mnt_k <= ka + ack_len);
      end
    end

    ks = -1; scyc = 0; done_k = -1; got_err = 1'b0; wrong = 0; busy = 0; buf_bad = 0;
    fired = 1'b0; cur_v = 1'b0; prev_v = 1'b0; cur_a = '0; prev_a = '0;
    limit = 2 + TMO + ack_dly + ack_len + 10;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) begin
        if (ks < 0) ks = k;
        scyc++;
        if ((sd_rd == wr) || (sd_wr != wr)) wrong++;
      end
      if (prev_v && (sd_buff_din !== mem[prev_a])) buf_bad++;
      if (done) begin
        done_k = k; got_err = err;
        if (req_ready) busy++;
        break;
      end
      if (req_ready) busy++;
      @(posedge clk_sys); #1;
      j = k + 1;
      ackon = ack_en && (ks > 0) && (j >= ks + ack_dly) && (j < ks + ack_dly + ack_len);
      sd_ack = ackon;
      prev_v = cur_v; prev_a = cur_a; cur_v = 1'b0;
      if (ackon) begin
        idx = j - (ks + ack_dly);
        cur_a = base + 8'(idx);
        sd_buff_addr = cur_a;
        if (wr) begin
          sd_buff_wr = 1'b0;
          cur_v = 1'b1;
        end else begin
          d = seq_data ? 16'(idx) : 16'($urandom);
          sd_buff_wr = 1'b1; sd_buff_dout = d;
          mem[cur_a] = d;
        end
      end else begin
        // writes without sd_ack must be ignored by the buffer
        sd_buff_wr   = ($urandom_range(0, 3) == 0);
        sd_buff_addr = 8'($urandom);
        sd_buff_dout = 16'($urandom);
      end
      img_mounted = (j == mnt_k);
      if (j == mnt_k) begin
        img_size = n_size; img_readonly = n_ro; fired = 1'b1;
      end
    end
    @(posedge clk_sys); #1;
    sd_ack = 1'b0; sd_buff_wr = 1'b0; img_mounted = 1'b0;
    if (fired) model_mount(n_size, n_ro);

    chk("done_cycle", done_k, e_done);
    chk("err", got_err, e_err);
    chk("strobe_start", ks, e_ks);
    chk("strobe_len", scyc, e_scyc);
    chk("strobe_dir", wrong, 0);
    chk("ready_busy", busy, 0);
    if (wr) chk("buff_din", buf_bad, 0);
    chk("sd_lba", sd_lba, exp_lba);
    @(negedge clk_sys);
    chk("done_pulse", done, 1'b0);
    chk("ready_idle", req_ready, 1'b1);
  endtask

  function automatic logic [63:0] rand_size();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return 64'd0;
    if (r == 1) return {32'($urandom), 32'($urandom)};
    return 64'($urandom_range(0, 8)) * 64'd512 + 64'($urandom_range(0, 511));
  endfunction

  initial begin
    int dn, mode, adly, alen, mk;
    bit wr, ro;
    logic [31:0] lba;
    logic [63:0] sz;

    reset = 1'b1; img_mounted = 1'b0; img_size = '0; img_readonly = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_lba = '0;
    core_addr = '0; core_wdata = '0; core_we = 1'b0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    m_mounted = 1'b0; m_ro = 1'b0; m_nsect = '0; exp_lba = '0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd", sd_rd, 1'b0);
    chk("rst_wr", sd_wr, 1'b0);
    chk("rst_lba", sd_lba, 32'd0);

    core_fill(1'b0);

    // 1 MiB rw image, read lba 5, ack 3 cycles later, 256 words of i
    do_mount(64'd1 << 20, 1'b0);
    run_req(1'b0, 32'd5, 1'b1, 3, 256, -1, '0, 1'b0, 1'b1, 8'd0);
    core_check();

    // lba == nsect rejected in CHECK
    run_req(1'b0, 32'd2048, 1'b1, 3, 4, -1, '0, 1'b0, 1'b0, 8'd0);
    run_req(1'b0, 32'd2047, 1'b1, 1, 3, -1, '0, 1'b0, 1'b0, 8'd9);

    // read-only image
    do_mount(64'd1 << 20, 1'b1);
    run_req(1'b1, 32'd0, 1'b1, 2, 4, -1, '0, 1'b0, 1'b0, 8'd0);
    run_req(1'b0, 32'd0, 1'b1, 2, 4, -1, '0, 1'b0, 1'b0, 8'd40);

    // write lba 7 from a patterned buffer
    do_mount(64'd1 << 20, 1'b0);
    core_fill(1'b1);
    run_req(1'b1, 32'd7, 1'b1, 2, 256, -1, '0, 1'b0, 1'b0, 8'd0);

    // no ack -> timeout
    run_req(1'b0, 32'd1, 1'b0, 1, 1, -1, '0, 1'b0, 1'b0, 8'd0);

    // remount while waiting for ack, then while transferring
    run_req(1'b0, 32'd3, 1'b1, 5, 4, 3, 64'd1 << 20, 1'b0, 1'b0, 8'd0);
    run_req(1'b0, 32'd3, 1'b1, 2, 6, 6, 64'd1 << 20, 1'b0, 1'b0, 8'd100);
    core_check();

    // reset during XFER
    @(posedge clk_sys); #1;
    req_valid = 1'b1; req_write = 1'b0; req_lba = 32'd3;
    @(posedge clk_sys); #1; req_valid = 1'b0;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1; sd_ack = 1'b1;
    @(posedge clk_sys); #1;
    @(negedge clk_sys);
    chk("xfer_rd_low", sd_rd, 1'b0);
    chk("xfer_busy", req_ready, 1'b0);
    @(posedge clk_sys); #1; reset = 1'b1;
    @(posedge clk_sys); #1; reset = 1'b0; sd_ack = 1'b0;
    @(negedge clk_sys);
    chk("rst2_rd", sd_rd, 1'b0);
    chk("rst2_wr", sd_wr, 1'b0);
    chk("rst2_ready", req_ready, 1'b1);
    chk("rst2_lba", sd_lba, 32'd0);
    dn = 0;
    repeat (8) begin
      @(negedge clk_sys);
      if (done) dn++;
    end
    chk("rst2_no_done", dn, 0);
    m_mounted = 1'b0; m_ro = 1'b0; m_nsect = '0; exp_lba = '0;
    run_req(1'b0, 32'd0, 1'b1, 1, 2, -1, '0, 1'b0, 1'b0, 8'd0);
    core_check();
    // mount in the same cycle as the request
    run_req(1'b0, 32'd10, 1'b1, 1, 3, 0, 64'd1 << 20, 1'b0, 1'b0, 8'd200);

    // randomized transactions
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) == 0) do_mount(rand_size(), 1'($urandom_range(0, 1)));
      wr   = 1'($urandom_range(0, 1));
      adly = $urandom_range(1, 6);
      alen = $urandom_range(1, 20);
      mode = $urandom_range(0, 9);
      sz   = rand_size();
      ro   = 1'($urandom_range(0, 3) == 0);
      if (m_nsect < 32'd16) lba = 32'($urandom_range(0, int'(m_nsect) + 1));
      else lba = 32'($urandom_range(0, 20));
      mk = -1;
      if (mode == 2) mk = $urandom_range(2, 1 + adly);
      if (mode == 3) mk = $urandom_range(3 + adly, 2 + adly + alen);
      if (mode == 4) mk = 0;
      if (wr) core_fill(1'b0);
      run_req(wr, lba, (mode != 1), adly, alen, mk, sz, ro, 1'b0, 8'($urandom));
      if (!wr) core_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
